// File: rtl/_dff_pipe_en_pkg.sv
// Shared defaults and helpers for the enable-controlled register pipeline.
package _dff_pipe_en_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Counter width able to hold every value 0..depth.
   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/_dff_pipe_en_if.sv
// Beat interface of the pipeline; the occ signal exists only with DFF_PIPE_OCC_EN.
interface _dff_pipe_en_if
   import _dff_pipe_en_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
`ifdef DFF_PIPE_OCC_EN
   , parameter int DEPTH = DEF_DEPTH
`endif
);

   logic             en;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             q_valid;

`ifdef DFF_PIPE_OCC_EN
   logic [occ_w(DEPTH)-1:0] occ;

   modport master (output en, flush, in_valid, d, input q, q_valid, occ);
   modport slave  (input en, flush, in_valid, d, output q, q_valid, occ);
`else
   modport master (output en, flush, in_valid, d, input q, q_valid);
   modport slave  (input en, flush, in_valid, d, output q, q_valid);
`endif

endinterface

// File: rtl/_dff_pipe_en_dffr_en.sv
// W-bit register with synchronous active-high reset to zero and load enable.
module _dffr_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/_dff_pipe_en.sv
// Stallable DEPTH-stage delay line with per-stage valid and flush.
// Optional registered occupancy count enabled by macro DFF_PIPE_OCC_EN.
module _dff_pipe_en
   import _dff_pipe_en_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input logic          clk,
   input logic          rst,
   _dff_pipe_en_if.slave bus
);

   logic [WIDTH-1:0] data_p [DEPTH];
   logic [0:0]       vld_p  [DEPTH];

   // Flush clears valids but leaves data untouched, and blocks the incoming beat.
   logic data_en;
   logic vld_clr;

   assign data_en = bus.en & ~bus.flush;
   assign vld_clr = rst | bus.flush;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         _dffr_en #(.W(WIDTH)) u_data (
            .clk (clk),
            .rst (rst),
            .en  (data_en),
            .d   (bus.d),
            .q   (data_p[k])
         );
         _dffr_en #(.W(1)) u_vld (
            .clk (clk),
            .rst (vld_clr),
            .en  (bus.en),
            .d   (bus.in_valid),
            .q   (vld_p[k])
         );
      end else begin : g_body
         _dffr_en #(.W(WIDTH)) u_data (
            .clk (clk),
            .rst (rst),
            .en  (data_en),
            .d   (data_p[k-1]),
            .q   (data_p[k])
         );
         _dffr_en #(.W(1)) u_vld (
            .clk (clk),
            .rst (vld_clr),
            .en  (bus.en),
            .d   (vld_p[k-1]),
            .q   (vld_p[k])
         );
      end
   end

   // ---- output stage ----
   assign bus.q       = data_p[DEPTH-1];
   assign bus.q_valid = vld_p[DEPTH-1][0];

`ifdef DFF_PIPE_OCC_EN
   localparam int OW = occ_w(DEPTH);

   logic [OW-1:0] occ_p0;

   // Bounded step keeps the count inside 0..DEPTH.
   function automatic logic [OW-1:0] occ_step(input logic [OW-1:0] cur,
                                              input logic inc, input logic dec);
      logic [OW-1:0] nxt;
      nxt = cur;
      if (inc && !dec && cur != OW'(DEPTH))
         nxt = cur + OW'(1);
      else if (!inc && dec && cur != '0)
         nxt = cur - OW'(1);
      return nxt;
   endfunction

   always_ff @(posedge clk) begin
      if (rst || bus.flush)
         occ_p0 <= '0;
      else if (bus.en)
         occ_p0 <= occ_step(occ_p0, bus.in_valid, vld_p[DEPTH-1][0]);
   end

   assign bus.occ = occ_p0;
`endif

endmodule

// File: tb/tb__dff_pipe_en.sv
// Randomized and directed bench for _dff_pipe_en against a beat-history model.
module tb__dff_pipe_en;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   _dff_pipe_en_if #(
      .WIDTH(WIDTH)
`ifdef DFF_PIPE_OCC_EN
      , .DEPTH(DEPTH)
`endif
   ) bus ();

   _dff_pipe_en #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic             v;
      logic [WIDTH-1:0] d;
   } beat_t;

   // Last DEPTH beats accepted on enabled edges, oldest first.
   beat_t hist[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_edge(input logic r, input logic e, input logic f,
                                      input logic iv, input logic [WIDTH-1:0] dd);
      if (r) begin
         hist.delete();
      end else if (f) begin
         foreach (hist[i]) hist[i].v = 1'b0;
      end else if (e) begin
         hist.push_back('{v: iv, d: dd});
         if (hist.size() > DEPTH) void'(hist.pop_front());
      end
   endfunction

   task automatic check_outputs(input string tag);
      logic [WIDTH-1:0] eq;
      logic             ev;
      int               cnt;
      eq  = '0;
      ev  = 1'b0;
      cnt = 0;
      if (hist.size() == DEPTH) begin
         eq = hist[0].d;
         ev = hist[0].v;
      end
      foreach (hist[i]) if (hist[i].v) cnt++;
      check_val({tag, ".q"}, 32'(bus.q), 32'(eq));
      check_val({tag, ".q_valid"}, 32'(bus.q_valid), 32'(ev));
`ifdef DFF_PIPE_OCC_EN
      check_val({tag, ".occ"}, 32'(bus.occ), 32'(cnt));
`else
      if (cnt < 0) check_val({tag, ".cnt"}, 32'(cnt), 32'(0));
`endif
   endtask

   task automatic cycle(input string tag, input logic r, input logic e, input logic f,
                        input logic iv, input logic [WIDTH-1:0] dd);
      rst          = r;
      bus.en       = e;
      bus.flush    = f;
      bus.in_valid = iv;
      bus.d        = dd;
      @(posedge clk);
      model_edge(r, e, f, iv, dd);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      // Reset with live-looking inputs.
      cycle("reset0", 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
      cycle("reset1", 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);

      // Continuous stream: 11,22,33,44 then more full beats.
      for (int i = 1; i <= 10; i++)
         cycle("stream", 1'b0, 1'b1, 1'b0, 1'b1, 8'(i * 8'h11));

      // Load A5, move it to stage1, then stall.
      cycle("load_a5", 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
      cycle("load_nx", 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
      for (int i = 0; i < 5; i++)
         cycle("stall", 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
      for (int i = 0; i < 4; i++)
         cycle("resume", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

      // Bubbles: alternating valid.
      for (int i = 1; i <= 8; i++)
         cycle("bubble", 1'b0, 1'b1, 1'b0, 1'(i % 2), 8'(i));

      // Flush with an incoming beat that must be dropped.
      for (int i = 0; i < 3; i++)
         cycle("prefl", 1'b0, 1'b1, 1'b0, 1'b1, 8'(8'hC0 + i));
      cycle("flush", 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
      for (int i = 0; i < DEPTH + 1; i++)
         cycle("postfl", 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hE0 + i));

      // Fill, then reset while stalled.
      for (int i = 0; i < DEPTH; i++)
         cycle("fill", 1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h90 + i));
      cycle("midrst", 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
      cycle("afterrst", 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle("rand", 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
